// File: rtl/exec_pkg.sv
// Shared types for the execution slice: alu opcodes, exec FSM states and an
// opcode classifier. Also used by the alu and the upcoming decoder.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LD  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_NOT = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } exec_state_t;

    // Arithmetic ops are the only ones that update carry and can set overflow.
    function automatic logic is_arith(alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/acc_exec_if.sv
// Instruction handshake plus the alu operand/result bus of the execution stage.
// slave: the execution stage; master: the instruction source; alu: the alu side.
interface acc_exec_if
    import exec_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             instr_valid;
    logic             instr_ready;
    alu_op_t          instr_op;
    logic [WIDTH-1:0] instr_imm;
    logic             instr_use_c;

    alu_op_t          alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_ci;
    logic [WIDTH-1:0] alu_result;
    logic             alu_co;
    logic             alu_ov;

    modport slave (
        input  instr_valid, instr_op, instr_imm, instr_use_c,
        input  alu_result, alu_co, alu_ov,
        output instr_ready, alu_op, alu_a, alu_b, alu_ci
    );

    modport master (
        output instr_valid, instr_op, instr_imm, instr_use_c,
        input  instr_ready
    );

    modport alu (
        input  alu_op, alu_a, alu_b, alu_ci,
        output alu_result, alu_co, alu_ov
    );
endinterface

// File: rtl/alu.sv
// Combinational alu. ADD: a+b+ci, co = carry out. SUB: a-b-ci, co = borrow.
// ov is signed overflow for ADD/SUB, 0 otherwise. NOT inverts a, LD passes b.
module alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ov
);
    logic [WIDTH:0] ext;

    // Result and flag generation per opcode.
    always_comb begin
        ext    = '0;
        result = '0;
        co     = 1'b0;
        ov     = 1'b0;
        case (op)
            OP_LD:  result = b;
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
                result = ext[WIDTH-1:0];
                co     = ext[WIDTH];
                ov     = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                ext    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ci};
                result = ext[WIDTH-1:0];
                co     = ext[WIDTH];
                ov     = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT: result = ~a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/acc_exec.sv
// Accumulator/flag execution stage. Accepts one instruction per handshake,
// feeds the external alu from the accumulator and latched immediate, and
// writes back the result and flags one edge later.
// Optional: define ACC_EXEC_ZERO_FLAG_EN to add the zero flag output.
//
//   state   | meaning
//   ST_IDLE | ready for an instruction; alu op forced to NOP
//   ST_EXEC | latched instruction on the alu; writeback at next edge
module acc_exec
    import exec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    acc_exec_if.slave        bus,
    input  logic             flags_clr,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             overflow,
    output logic             done
`ifdef ACC_EXEC_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);
    exec_state_t      state_q, state_d;
    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic             use_c_q, use_c_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ov_q, ov_d;
    logic             done_q, done_d;
`ifdef ACC_EXEC_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.alu_op      = (state_q == ST_EXEC) ? op_q : OP_NOP;
    assign bus.alu_a       = acc_q;
    assign bus.alu_b       = imm_q;
    // Carry before this instruction's own writeback feeds the alu.
    assign bus.alu_ci      = use_c_q & carry_q;

    assign acc      = acc_q;
    assign carry    = carry_q;
    assign overflow = ov_q;
    assign done     = done_q;
`ifdef ACC_EXEC_ZERO_FLAG_EN
    assign zero     = zero_q;
`endif

    // Next-state, instruction latch and writeback; flags_clr applied first so a
    // coincident writeback overrides it.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        imm_d   = imm_q;
        use_c_d = use_c_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ov_d    = ov_q;
        done_d  = 1'b0;
`ifdef ACC_EXEC_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        if (flags_clr) begin
            carry_d = 1'b0;
            ov_d    = 1'b0;
`ifdef ACC_EXEC_ZERO_FLAG_EN
            zero_d  = 1'b0;
`endif
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    op_d    = bus.instr_op;
                    imm_d   = bus.instr_imm;
                    use_c_d = bus.instr_use_c;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (op_q != OP_NOP) begin
                    acc_d = bus.alu_result;
                    if (is_arith(op_q)) begin
                        carry_d = bus.alu_co;
                        ov_d    = bus.alu_ov;
                    end else begin
                        ov_d    = 1'b0;
                    end
`ifdef ACC_EXEC_ZERO_FLAG_EN
                    zero_d = (bus.alu_result == '0);
`endif
                end
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            imm_q   <= '0;
            use_c_q <= 1'b0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef ACC_EXEC_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            use_c_q <= use_c_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
`ifdef ACC_EXEC_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end
endmodule

// File: tb/tb_acc_exec.sv
// Directed bench for acc_exec driving a real alu instance.
module tb_acc_exec;
    import exec_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       flags_clr;
    logic [7:0] acc;
    logic       carry;
    logic       overflow;
    logic       done;
`ifdef ACC_EXEC_ZERO_FLAG_EN
    logic       zero;
`endif
    int checks = 0;
    int errors = 0;
    int accepted;

    acc_exec_if #(.WIDTH(8)) bus ();

    acc_exec #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flags_clr (flags_clr),
        .acc       (acc),
        .carry     (carry),
        .overflow  (overflow),
        .done      (done)
`ifdef ACC_EXEC_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    alu #(.WIDTH(8)) u_alu (
        .op     (bus.alu_op),
        .a      (bus.alu_a),
        .b      (bus.alu_b),
        .ci     (bus.alu_ci),
        .result (bus.alu_result),
        .co     (bus.alu_co),
        .ov     (bus.alu_ov)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction from IDLE; optionally raise flags_clr on the writeback edge.
    task automatic issue(input alu_op_t op, input logic [7:0] imm, input logic use_c,
                         input logic clr_on_wb);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_imm   = imm;
        bus.instr_use_c = use_c;
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_op    = OP_NOP;
        bus.instr_imm   = 8'h00;
        bus.instr_use_c = 1'b0;
        check("exec_ready", {31'd0, bus.instr_ready}, 32'd0);
        check("exec_done", {31'd0, done}, 32'd0);
        flags_clr = clr_on_wb;
        tick();
        flags_clr = 1'b0;
        check("wb_done", {31'd0, done}, 32'd1);
        check("wb_ready", {31'd0, bus.instr_ready}, 32'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        flags_clr       = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_op    = OP_NOP;
        bus.instr_imm   = 8'h00;
        bus.instr_use_c = 1'b0;
        #1;
        check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
        check("rst_acc", {24'd0, acc}, 32'h00);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Build acc=0x01, carry=1, then reset while the next instruction is in EXEC.
        issue(OP_LD, 8'hFF, 1'b0, 1'b0);
        check("ld_ff", {24'd0, acc}, 32'hFF);
        issue(OP_ADD, 8'h02, 1'b0, 1'b0);
        check("pre_rst_acc", {24'd0, acc}, 32'h01);
        check("pre_rst_carry", {31'd0, carry}, 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr_op    = OP_LD;
        bus.instr_imm   = 8'h33;
        tick();
        bus.instr_valid = 1'b0;
        check("mid_exec_ready", {31'd0, bus.instr_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_acc", {24'd0, acc}, 32'h00);
        check("async_carry", {31'd0, carry}, 32'd0);
        check("async_ready", {31'd0, bus.instr_ready}, 32'd1);
        check("async_done", {31'd0, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_acc", {24'd0, acc}, 32'h00);
        check("post_rst_done", {31'd0, done}, 32'd0);

        // Signed overflow on 0x7F + 1.
        issue(OP_LD, 8'h7F, 1'b0, 1'b0);
        check("ld_7f", {24'd0, acc}, 32'h7F);
        issue(OP_ADD, 8'h01, 1'b0, 1'b0);
        check("add_ov_acc", {24'd0, acc}, 32'h80);
        check("add_ov_carry", {31'd0, carry}, 32'd0);
        check("add_ov_ov", {31'd0, overflow}, 32'd1);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // Carry out, then carry in through use_c.
        issue(OP_LD, 8'hFF, 1'b0, 1'b0);
        check("ld_clears_ov", {31'd0, overflow}, 32'd0);
        issue(OP_ADD, 8'h01, 1'b0, 1'b0);
        check("wrap_acc", {24'd0, acc}, 32'h00);
        check("wrap_carry", {31'd0, carry}, 32'd1);
        check("wrap_ov", {31'd0, overflow}, 32'd0);
`ifdef ACC_EXEC_ZERO_FLAG_EN
        check("zero_set", {31'd0, zero}, 32'd1);
`endif
        bus.instr_valid = 1'b1;
        bus.instr_op    = OP_ADD;
        bus.instr_imm   = 8'h00;
        bus.instr_use_c = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_use_c = 1'b0;
        check("exec_alu_ci", {31'd0, bus.alu_ci}, 32'd1);
        check("exec_alu_op", {29'd0, bus.alu_op}, 32'd2);
        tick();
        check("adc_acc", {24'd0, acc}, 32'h01);
        check("adc_carry", {31'd0, carry}, 32'd0);
`ifdef ACC_EXEC_ZERO_FLAG_EN
        check("zero_clr", {31'd0, zero}, 32'd0);
`endif

        // Signed overflow on subtract, then borrow, then logic op keeps carry.
        issue(OP_LD, 8'h80, 1'b0, 1'b0);
        issue(OP_SUB, 8'h01, 1'b0, 1'b0);
        check("sub_ov_acc", {24'd0, acc}, 32'h7F);
        check("sub_ov_ov", {31'd0, overflow}, 32'd1);
        check("sub_ov_carry", {31'd0, carry}, 32'd0);
        issue(OP_LD, 8'h00, 1'b0, 1'b0);
        issue(OP_SUB, 8'h01, 1'b0, 1'b0);
        check("borrow_acc", {24'd0, acc}, 32'hFF);
        check("borrow_carry", {31'd0, carry}, 32'd1);
        issue(OP_AND, 8'h0F, 1'b0, 1'b0);
        check("and_acc", {24'd0, acc}, 32'h0F);
        check("and_carry", {31'd0, carry}, 32'd1);
        check("and_ov", {31'd0, overflow}, 32'd0);
        issue(OP_XOR, 8'hFF, 1'b0, 1'b0);
        check("xor_acc", {24'd0, acc}, 32'hF0);

        // Valid held for 6 cycles: only alternate cycles are accepted.
        issue(OP_LD, 8'h00, 1'b0, 1'b0);
        bus.instr_valid = 1'b1;
        bus.instr_op    = OP_ADD;
        bus.instr_imm   = 8'h01;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.instr_ready) accepted++;
            tick();
        end
        bus.instr_valid = 1'b0;
        check("held_accepts", accepted, 32'd3);
        check("held_acc", {24'd0, acc}, 32'h03);

        // flags_clr loses to a coincident writeback, then clears alone.
        issue(OP_LD, 8'hFF, 1'b0, 1'b0);
        issue(OP_ADD, 8'h01, 1'b0, 1'b1);
        check("clr_wb_carry", {31'd0, carry}, 32'd1);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("clr_carry", {31'd0, carry}, 32'd0);
        check("clr_acc", {24'd0, acc}, 32'h00);
        issue(OP_LD, 8'h7F, 1'b0, 1'b0);
        issue(OP_ADD, 8'h01, 1'b0, 1'b0);
        check("pre_clr_ov", {31'd0, overflow}, 32'd1);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("clr_ov", {31'd0, overflow}, 32'd0);
        check("clr_keeps_acc", {24'd0, acc}, 32'h80);
        check("clr_keeps_ready", {31'd0, bus.instr_ready}, 32'd1);

        // NOP changes nothing but still pulses done.
        issue(OP_ADD, 8'h80, 1'b0, 1'b0);
        check("pre_nop_acc", {24'd0, acc}, 32'h00);
        check("pre_nop_carry", {31'd0, carry}, 32'd1);
        check("pre_nop_ov", {31'd0, overflow}, 32'd1);
        issue(OP_NOP, 8'h55, 1'b0, 1'b0);
        check("nop_acc", {24'd0, acc}, 32'h00);
        check("nop_carry", {31'd0, carry}, 32'd1);
        check("nop_ov", {31'd0, overflow}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
